// File: rtl/snake_pkg.sv
// Game-wide shared types and helpers for the snake game datapath.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } stretch_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter that saturates at zero and flags it.
// The pulse stretcher shares one instance for its HIGH and GAP phases.
module down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into fixed-width levels; events arriving
// mid-pulse are queued as a count and replayed with a guaranteed low gap.
module pulse_stretcher
    import snake_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_pulse,
    output logic                            out_level,
    output logic                            busy,
    output logic [$clog2(PEND_MAX+1)-1:0]   pending,
    output logic                            overflow
);

    localparam int CNT_W  = $clog2(max_int(HIGH_CYCLES, GAP_CYCLES) + 1);
    localparam int PEND_W = $clog2(PEND_MAX + 1);

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

    stretch_state_e    state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              level_q, busy_q;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_zero;

    down_counter #(.WIDTH(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (state_q != ST_IDLE),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        ovf_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        case (state_q)
            ST_IDLE: begin
                if (in_pulse) begin
                    state_d      = ST_HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = HIGH_LOAD;
                end
            end

            ST_HIGH: begin
                if (cnt_zero) begin
                    state_d      = ST_GAP;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end
                if (in_pulse) begin
                    if (pend_q != PEND_FULL) pend_d = pend_q + PEND_W'(1);
                    else                     ovf_d  = 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_zero && (pend_q != '0 || in_pulse)) begin
                    state_d      = ST_HIGH;
                    cnt_load     = 1'b1;
                    cnt_load_val = HIGH_LOAD;
                    // Dequeue and a simultaneous arrival cancel; with an empty queue the arrival is replayed directly.
                    if (pend_q != '0 && !in_pulse) pend_d = pend_q - PEND_W'(1);
                end else if (cnt_zero) begin
                    state_d = ST_IDLE;
                end else if (in_pulse) begin
                    if (pend_q != PEND_FULL) pend_d = pend_q + PEND_W'(1);
                    else                     ovf_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            level_q <= (state_d == ST_HIGH);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign out_level = level_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed scenarios for pulse_stretcher with HIGH_CYCLES=4, GAP_CYCLES=2, PEND_MAX=3;
// expected per-cycle waveforms are written out by hand in each test task.
module tb_pulse_stretcher;

    localparam int N = 48;

    logic       clk;
    logic       rst_n;
    logic       in_pulse;
    logic       out_level;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int checks;
    int failures;

    logic [N-1:0] obs_out, obs_busy, obs_ovf;
    logic [1:0]   obs_pend [N];
    logic [1:0]   exp_pend [N];

    pulse_stretcher #(
        .HIGH_CYCLES (4),
        .GAP_CYCLES  (2),
        .PEND_MAX    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pulse  (in_pulse),
        .out_level (out_level),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] rng(input int lo, input int hi);
        logic [N-1:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        in_pulse = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Runs cycles 0..N-1 from a fresh reset; outputs are sampled 1 time unit after each rising edge.
    task automatic run(input logic [N-1:0] pulses);
        do_reset();
        for (int c = 0; c < N; c++) begin
            in_pulse    = pulses[c];
            obs_out[c]  = out_level;
            obs_busy[c] = busy;
            obs_pend[c] = pending;
            obs_ovf[c]  = overflow;
            tick();
        end
        in_pulse = 1'b0;
    endtask

    task automatic compare_run(input string name, input logic [N-1:0] e_out,
                               input logic [N-1:0] e_busy, input logic [N-1:0] e_ovf);
        int bad;
        checks++;
        if (obs_out !== e_out) begin
            failures++;
            $display("FAIL %s out_level: got %h expected %h", name, obs_out, e_out);
        end
        checks++;
        if (obs_busy !== e_busy) begin
            failures++;
            $display("FAIL %s busy: got %h expected %h", name, obs_busy, e_busy);
        end
        checks++;
        if (obs_ovf !== e_ovf) begin
            failures++;
            $display("FAIL %s overflow: got %h expected %h", name, obs_ovf, e_ovf);
        end
        bad = -1;
        for (int c = N - 1; c >= 0; c--) if (obs_pend[c] !== exp_pend[c]) bad = c;
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s pending at cycle %0d: got %0d expected %0d",
                     name, bad, obs_pend[bad], exp_pend[bad]);
        end
    endtask

    task automatic set_pend(input int lo, input int hi, input logic [1:0] v);
        for (int c = lo; c <= hi; c++) exp_pend[c] = v;
    endtask

    task automatic test_reset();
        in_pulse = 1'b1;
        rst_n    = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_level, busy, pending, overflow} !== 5'b0) begin
            failures++;
            $display("FAIL reset_state: got out=%b busy=%b pend=%0d ovf=%b expected all 0",
                     out_level, busy, pending, overflow);
        end
        in_pulse = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_single();
        for (int c = 0; c < N; c++) exp_pend[c] = 2'd0;
        run(rng(10, 10));
        compare_run("single", rng(11, 14), rng(11, 16), '0);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < N; c++) exp_pend[c] = 2'd0;
        set_pend(13, 16, 2'd1);
        run(rng(10, 10) | rng(12, 12));
        compare_run("back_to_back", rng(11, 14) | rng(17, 20), rng(11, 22), '0);
    endtask

    task automatic test_overflow();
        for (int c = 0; c < N; c++) exp_pend[c] = 2'd0;
        set_pend(12, 12, 2'd1);
        set_pend(13, 13, 2'd2);
        set_pend(14, 16, 2'd3);
        set_pend(17, 22, 2'd2);
        set_pend(23, 28, 2'd1);
        run(rng(10, 14));
        compare_run("overflow", rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32),
                    rng(11, 34), rng(15, 15));
    endtask

    task automatic test_last_gap_direct();
        for (int c = 0; c < N; c++) exp_pend[c] = 2'd0;
        run(rng(10, 10) | rng(16, 16));
        compare_run("last_gap_direct", rng(11, 14) | rng(17, 20), rng(11, 22), '0);
    endtask

    task automatic test_last_gap_full();
        for (int c = 0; c < N; c++) exp_pend[c] = 2'd0;
        set_pend(12, 12, 2'd1);
        set_pend(13, 13, 2'd2);
        set_pend(14, 22, 2'd3);
        set_pend(23, 28, 2'd2);
        set_pend(29, 34, 2'd1);
        run(rng(10, 14) | rng(16, 16));
        compare_run("last_gap_full",
                    rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32) | rng(35, 38),
                    rng(11, 40), rng(15, 15));
    endtask

    task automatic test_held_input();
        for (int c = 0; c < N; c++) exp_pend[c] = 2'd0;
        set_pend(12, 12, 2'd1);
        set_pend(13, 16, 2'd2);
        set_pend(17, 22, 2'd1);
        run(rng(10, 12));
        compare_run("held_input", rng(11, 14) | rng(17, 20) | rng(23, 26), rng(11, 28), '0);
    endtask

    task automatic test_reset_mid_high();
        logic [N-1:0] got;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            in_pulse = (c == 10 || c == 11);
            tick();
        end
        in_pulse = 1'b0;
        checks++;
        if (out_level !== 1'b1 || pending !== 2'd1) begin
            failures++;
            $display("FAIL mid_high_before_reset: got out=%b pend=%0d expected out=1 pend=1",
                     out_level, pending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_level, busy, pending, overflow} !== 5'b0) begin
            failures++;
            $display("FAIL mid_high_async_reset: got out=%b busy=%b pend=%0d ovf=%b expected all 0",
                     out_level, busy, pending, overflow);
        end
        for (int c = 13; c < 16; c++) tick();
        rst_n = 1'b1;
        got = '0;
        for (int c = 16; c < 30; c++) begin
            in_pulse = (c == 20);
            got[c]   = out_level;
            tick();
        end
        in_pulse = 1'b0;
        checks++;
        if (got !== rng(21, 24)) begin
            failures++;
            $display("FAIL after_reset_pulse out_level: got %h expected %h", got, rng(21, 24));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        in_pulse = 1'b0;
        rst_n    = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_last_gap_direct();
        test_last_gap_full();
        test_held_input();
        test_reset_mid_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Converts single-cycle event pulses (from the game's edge-detect stage) back into fixed-width level outputs, such as LED flashes and buzzer enables for "food eaten" or "game over" events. Events that arrive while a stretched pulse is in progress are counted and replayed in order, separated by a guaranteed low gap. The block sits between event sources and slow output drivers, and is the level-side counterpart of the pulse-generation stage.

## Interface
- HIGH_CYCLES, default 4: output high width in cycles, must be ≥1
- GAP_CYCLES, default 2: minimum low time between consecutive stretched pulses, must be ≥1
- PEND_MAX, default 3: maximum queued events, must be ≥1
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_pulse  in  1  event input, sampled every rising edge; each high cycle counts as one event
- out_level  out  1  stretched level output, registered
- busy  out  1  high when the state is not IDLE, registered
- pending  out  $clog2(PEND_MAX+1)  number of queued events not yet replayed
- overflow  out  1  one-cycle pulse when an event is dropped because the queue is full

## Operation
- States are IDLE, HIGH and GAP. A down-counter `cnt` is $clog2(max(HIGH_CYCLES,GAP_CYCLES)+1) bits wide.
- **IDLE**
  - out_level=0, busy=0.
  - If in_pulse=1: go to HIGH and load cnt=HIGH_CYCLES-1.
- **HIGH**
  - out_level=1.
  - If cnt≠0: decrement cnt.
  - If cnt=0: go to GAP and load cnt=GAP_CYCLES-1.
- **GAP**
  - out_level=0.
  - If cnt≠0: decrement cnt.
  - If cnt=0 (last gap cycle), the next state is chosen as follows:
    - pending>0: go to HIGH, load cnt=HIGH_CYCLES-1, and pending-1 (the net change is 0 if in_pulse is also high that cycle).
    - pending=0 and in_pulse=1: go to HIGH directly; pending stays 0.
    - otherwise: go to IDLE.
- **Queueing** (in HIGH, and in GAP except the case consumed above)
  - in_pulse=1 with pending<PEND_MAX: pending+1.
  - in_pulse=1 with pending=PEND_MAX: event is dropped and overflow=1 on the next cycle.
  - Exception: on the last gap cycle with pending=PEND_MAX and in_pulse=1, the dequeue frees a slot, so pending stays PEND_MAX and there is no overflow.
- The block holds no other state. Any event is either replayed in full or flagged by overflow.

## Timing
- **Reset:** while rst_n=0, out_level=0, busy=0, pending=0, overflow=0, state=IDLE, cnt=0. Assertion takes effect immediately, including mid-HIGH.
- **Latency:** in_pulse high in cycle n from IDLE gives out_level high in cycles n+1 through n+HIGH_CYCLES, then low for at least GAP_CYCLES.
- **Throughput:** one stretched pulse per HIGH_CYCLES+GAP_CYCLES cycles, with no idle cycle between a GAP and the next queued HIGH.
- busy rises in the same cycle as out_level and falls in the first IDLE cycle.
- overflow is registered, high for exactly one cycle per dropped event.
- pending changes at most by ±1 per cycle.

## Structure
- The state enum (IDLE/HIGH/GAP) goes in the shared package `snake_pkg`, next to other game-wide typedefs.
- One sub-module is natural: `down_counter`, a loadable down-counter with a zero flag, reused for both the HIGH and GAP phases.
- The pending counter and overflow register stay in the top level.

## Test plan
All scenarios use HIGH_CYCLES=4, GAP_CYCLES=2, PEND_MAX=3.
- Single in_pulse at cycle 10 -> out_level=1 in cycles 11–14, 0 in cycles 15–16, busy=1 in cycles 11–16, IDLE at 17.
- Pulses at cycles 10 and 12 -> pending=1 from cycle 13; second HIGH in cycles 17–20, GAP in 21–22, pending=0 from cycle 17.
- Pulses at cycles 10–14 -> pending reaches 3 at cycle 14; overflow=1 in cycle 15 only; three further HIGH windows starting at cycles 17, 23 and 29.
- Pulse at 10 and pulse at 16 (last gap cycle, pending=0) -> HIGH in cycles 17–20, pending stays 0, overflow stays 0.
- Pulse at 10, then rst_n=0 at cycle 12 -> out_level, busy and pending go to 0 immediately; after release, a pulse at 20 gives HIGH in cycles 21–24.
- in_pulse held high for cycles 10–12 -> HIGH in cycles 11–14 and pending=2 at cycle 13, followed by two replays.
